chunked_add_sequencer: RTL and testbench



---
 rtl/chunked_add_sequencer.sv | 172 +++++++++++++++++
 tb/tb_chunked_add_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_add_sequencer.sv
// chunked_add_sequencer: multi-cycle WIDTH-bit adder built from one shared
// CHUNK-bit ripple adder. Operands arrive over a valid/ready handshake, one
// CHUNK slice is added per cycle with the carry chained through a register,
// and the result is offered over a second valid/ready handshake.
// Optional feature macro: CHUNKED_ADD_SEQ_SUB_EN adds a 'sub' input that turns
// the operation into a - b (cout = 1 means no borrow).

// Plain CHUNK-bit ripple-carry adder, purely combinational.
module ripple_adder_generic #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  // Ripple the carry bit by bit from the LSB.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so each bit sees the carry
    // computed for the previous bit within the same evaluation.
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[W];
  end

endmodule

module chunked_add_sequencer #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CHUNKED_ADD_SEQ_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Reject configurations where the slices would not tile the operand.
  if (CHUNK <= 0 || WIDTH <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("chunked_add_sequencer: WIDTH must be a positive multiple of CHUNK");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic [CHUNK-1:0] add_s;
  logic             add_c;

  // Subtraction is a + ~b + 1, so only the captured B and the initial carry
  // differ between the two operations.
`ifdef CHUNKED_ADD_SEQ_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  ripple_adder_generic #(.W(CHUNK)) u_adder (
    .a    (a_q[idx_q*CHUNK +: CHUNK]),
    .b    (b_q[idx_q*CHUNK +: CHUNK]),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_c)
  );

  // Next-state logic: accept in IDLE, one slice per cycle in RUN, hold in DONE.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = add_s;
        carry_d = add_c;
        if (idx_q == IDX_LAST) begin
          cout_d  = add_c;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset wins over any handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from values sampled at the same edge.
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Self-checking bench for chunked_add_sequencer: a table of directed vectors,
// hand-written corner sequences (ignored in_valid, mid-run reset, N == 1) and
// randomized operands compared against an arithmetic reference model.
// With CHUNKED_ADD_SEQ_SUB_EN defined the subtraction cases are exercised too.
module tb_chunked_add_sequencer;

  localparam int WIDTH = 8;
  localparam int CHUNK = 2;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             sub;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, busy;

  // Second instance with CHUNK == WIDTH (single RUN cycle).
  logic             n1_sub;
  logic             n1_in_valid, n1_in_ready;
  logic [WIDTH-1:0] n1_a, n1_b;
  logic             n1_cin;
  logic             n1_out_valid, n1_out_ready;
  logic [WIDTH-1:0] n1_sum;
  logic             n1_cout, n1_busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  chunked_add_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  chunked_add_sequencer #(.WIDTH(WIDTH), .CHUNK(WIDTH)) dut_n1 (
    .clk       (clk),
    .rst       (rst),
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    .sub       (n1_sub),
`endif
    .in_valid  (n1_in_valid),
    .in_ready  (n1_in_ready),
    .a         (n1_a),
    .b         (n1_b),
    .cin       (n1_cin),
    .out_valid (n1_out_valid),
    .out_ready (n1_out_ready),
    .sum       (n1_sum),
    .cout      (n1_cout),
    .busy      (n1_busy)
  );

  typedef struct {
    string            name;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    int               hold;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned arithmetic. Subtraction reports no-borrow on cout.
  function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic c, input logic s);
    int unsigned r;
    if (s) begin
      r = (int'(x) - int'(y)) & ((1 << WIDTH) - 1);
      return {(x >= y), r[WIDTH-1:0]};
    end
    r = int'(x) + int'(y) + int'(c);
    return r[WIDTH:0];
  endfunction

  // One full transaction on the N-beat instance, optionally stalling the result.
  task automatic run_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tc, input logic ts, input int hold,
                        input logic [WIDTH-1:0] esum, input logic ecout);
    int lat;
    check($sformatf("%s in_ready_before", name), in_ready, 1);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check($sformatf("%s latency", name), lat, N);
    for (int i = 0; i < hold; i++) begin
      check($sformatf("%s stall%0d sum", name, i), sum, esum);
      check($sformatf("%s stall%0d cout", name, i), cout, ecout);
      check($sformatf("%s stall%0d in_ready", name, i), in_ready, 0);
      check($sformatf("%s stall%0d busy", name, i), busy, 1);
      tick();
      check($sformatf("%s stall%0d out_valid", name, i), out_valid, 1);
    end
    check($sformatf("%s sum", name), sum, esum);
    check($sformatf("%s cout", name), cout, ecout);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("%s in_ready_after", name), in_ready, 1);
    check($sformatf("%s out_valid_after", name), out_valid, 0);
  endtask

  // One transaction on the single-beat instance.
  task automatic run_n1(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tc);
    int lat;
    logic [WIDTH:0] exp;
    exp = ref_op(ta, tb_v, tc, 1'b0);
    n1_a = ta; n1_b = tb_v; n1_cin = tc; n1_in_valid = 1'b1;
    tick();
    n1_in_valid = 1'b0;
    n1_a = WIDTH'($urandom); n1_b = WIDTH'($urandom);
    lat = 0;
    while (!n1_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check($sformatf("%s latency", name), lat, 1);
    check($sformatf("%s sum", name), n1_sum, exp[WIDTH-1:0]);
    check($sformatf("%s cout", name), n1_cout, exp[WIDTH]);
    n1_out_ready = 1'b1;
    tick();
    n1_out_ready = 1'b0;
    check($sformatf("%s in_ready_after", name), n1_in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   lat;
    logic seen_valid;
    logic [WIDTH:0] exp;

    vecs[0] = '{"ff_plus_01",   8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1};
    vecs[1] = '{"5a_plus_25_c", 8'h5A, 8'h25, 1'b1, 3, 8'h80, 1'b0};
    vecs[2] = '{"zero",         8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0};
    vecs[3] = '{"ff_ff_c",      8'hFF, 8'hFF, 1'b1, 1, 8'hFF, 1'b1};
    vecs[4] = '{"aa_plus_55",   8'hAA, 8'h55, 1'b0, 0, 8'hFF, 1'b0};

    rst = 1'b1; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    n1_sub = 1'b0; n1_in_valid = 1'b0; n1_out_ready = 1'b0; n1_a = '0; n1_b = '0; n1_cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 1);

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].hold,
             vecs[i].sum, vecs[i].cout);
    end

    // in_valid held high through RUN/DONE with a different pair: not captured.
    a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
    tick();
    a = 8'h10; b = 8'h20;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("ignore latency", lat, N);
    check("ignore first sum", sum, 8'h33);
    check("ignore first cout", cout, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ignore back_to_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("ignore second accepted", busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("ignore second latency", lat, N);
    check("ignore second sum", sum, 8'h30);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the second RUN cycle discards the operation.
    a = 8'hF0; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst sum", sum, 0);
    check("midrst cout", cout, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst busy", busy, 0);
    out_ready = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen_valid |= out_valid;
    end
    out_ready = 1'b0;
    check("midrst no_result", seen_valid, 0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      exp = ref_op(ra, rb, rc, 1'b0);
      run_op($sformatf("rand%0d", i), ra, rb, rc, 1'b0, int'($urandom_range(0, 2)),
             exp[WIDTH-1:0], exp[WIDTH]);
    end

    // Single-beat configuration.
    run_n1("n1_80_80", 8'h80, 8'h80, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_n1($sformatf("n1_rand%0d", i), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end

`ifdef CHUNKED_ADD_SEQ_SUB_EN
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 0, 8'hFE, 1'b0);
    run_op("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 0, 8'h02, 1'b1);
    for (int i = 0; i < 10; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc, rs;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      exp = ref_op(ra, rb, rc, rs);
      run_op($sformatf("subrand%0d", i), ra, rb, rc, rs, 0, exp[WIDTH-1:0], exp[WIDTH]);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
